// File: rtl/hex_display_scheduler.sv
// hex_display_scheduler
// Time-shares the four 7-segment displays HEX3..HEX0 between four BCD
// sources. One source is granted at a time. The grant rotates round-robin
// on a dwell timer (auto mode) or on a debounced key press (manual mode).
// Segment outputs are active-low. The printed bit order is a..g from left
// to right, so bit 6 = a and bit 0 = g.

module hex_display_scheduler #(
    parameter int TICK_DIV   = 50_000_000,
    parameter int DWELL      = 3,
    parameter int DEB_CYCLES = 1_000_000
) (
    input  logic        CLOCK_50Mhz,
    input  logic        RESET_N,
    input  logic        key_n,
    input  logic        auto_en,
    input  logic [3:0]  req,
    input  logic [63:0] src_bcd,
    output logic [3:0]  grant,
    output logic [1:0]  page,
    output logic [6:0]  HEX0,
    output logic [6:0]  HEX1,
    output logic [6:0]  HEX2,
    output logic [6:0]  HEX3
);

    localparam int PW  = (TICK_DIV > 1)   ? $clog2(TICK_DIV)   : 1;
    localparam int DBW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam int DWW = (DWELL > 1)      ? $clog2(DWELL)      : 1;

    localparam logic [PW-1:0]  PRE_MAX   = PW'(TICK_DIV - 1);
    localparam logic [DBW-1:0] DEB_MAX   = DBW'(DEB_CYCLES - 1);
    localparam logic [DWW-1:0] DWELL_MAX = DWW'(DWELL - 1);

    localparam logic [0:0] STATE_IDLE = 1'b0;
    localparam logic [0:0] STATE_SHOW = 1'b1;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Active-low segment pattern for one BCD digit; non-decimal codes are blanked.
    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b0000001;
            4'd1:    s = 7'b1001111;
            4'd2:    s = 7'b0010010;
            4'd3:    s = 7'b0000110;
            4'd4:    s = 7'b1001100;
            4'd5:    s = 7'b0100100;
            4'd6:    s = 7'b0100000;
            4'd7:    s = 7'b0001111;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0000100;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

    // First requester found searching circularly from p+1, with p itself
    // checked last. Returns {found, index}.
    function automatic logic [2:0] next_req(input logic [3:0] r, input logic [1:0] p);
        logic [2:0] res;
        logic [1:0] idx;
        res = 3'b000;
        // Walk from the farthest candidate to the nearest, so the nearest wins.
        for (int k = 4; k >= 1; k--) begin
            idx = p + 2'(k);
            if (r[idx]) begin
                res = {1'b1, idx};
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    // ------------------------------------------------------------------
    // Registers and their next-state values
    // ------------------------------------------------------------------
    logic [PW-1:0]  pre_q, pre_d;
    logic [1:0]     sync_q;
    logic           deb_q, deb_d;
    logic [DBW-1:0] deb_cnt_q, deb_cnt_d;
    logic           deb_prev_q;
    logic [0:0]     state_q, state_d;
    logic [3:0]     grant_q, grant_d;
    logic [1:0]     page_q, page_d;
    logic [DWW-1:0] dwell_q, dwell_d;
    logic [6:0]     hex0_q, hex0_d, hex1_q, hex1_d, hex2_q, hex2_d, hex3_q, hex3_d;

    logic           tick_s;
    logic           press_s;
    logic           adv_s;
    logic [2:0]     nxt_s;
    logic [15:0]    cur_s;
    logic           z3_s, z2_s, z1_s;

    // Free-running prescaler; tick is high for the single cycle at the top count.
    always_comb begin
        tick_s = (pre_q == PRE_MAX);
        if (tick_s) begin
            pre_d = '0;
        end else begin
            pre_d = pre_q + PW'(1);
        end
    end

    // Debounce: adopt the synchronised level after it has differed for DEB_CYCLES cycles.
    always_comb begin
        deb_d     = deb_q;
        deb_cnt_d = '0;
        if (sync_q[1] != deb_q) begin
            if (deb_cnt_q == DEB_MAX) begin
                deb_d     = sync_q[1];
                deb_cnt_d = '0;
            end else begin
                deb_cnt_d = deb_cnt_q + DBW'(1);
            end
        end else begin
            deb_cnt_d = '0;
        end
    end

    assign press_s = deb_prev_q & ~deb_q;

    // Grant FSM: at most one regrant per cycle, however many advance causes coincide.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        page_d  = page_q;
        dwell_d = dwell_q;
        nxt_s   = next_req(req, page_q);
        adv_s   = (auto_en && tick_s && (dwell_q == DWELL_MAX)) || press_s || !req[page_q];
        case (state_q)
            STATE_IDLE: begin
                dwell_d = '0;
                if (nxt_s[2]) begin
                    state_d = STATE_SHOW;
                    page_d  = nxt_s[1:0];
                    grant_d = 4'b0001 << nxt_s[1:0];
                end else begin
                    state_d = STATE_IDLE;
                    grant_d = 4'b0000;
                end
            end
            STATE_SHOW: begin
                if (adv_s) begin
                    dwell_d = '0;
                    if (nxt_s[2]) begin
                        page_d  = nxt_s[1:0];
                        grant_d = 4'b0001 << nxt_s[1:0];
                    end else begin
                        // Nobody left to show; page keeps the last granted source.
                        state_d = STATE_IDLE;
                        grant_d = 4'b0000;
                    end
                end else if (tick_s && (dwell_q != DWELL_MAX)) begin
                    // Saturate so that dwell time spent in manual mode cannot wrap.
                    dwell_d = dwell_q + DWW'(1);
                end else begin
                    dwell_d = dwell_q;
                end
            end
            default: begin
                state_d = STATE_IDLE;
                grant_d = 4'b0000;
                dwell_d = '0;
            end
        endcase
    end

    // Decode the registered page's value with leading-zero suppression on HEX3..HEX1.
    always_comb begin
        cur_s = src_bcd[{page_q, 4'b0000} +: 16];
        z3_s  = (cur_s[15:12] == 4'd0);
        z2_s  = z3_s && (cur_s[11:8] == 4'd0);
        z1_s  = z2_s && (cur_s[7:4] == 4'd0);
        if (state_q == STATE_SHOW) begin
            hex3_d = z3_s ? SEG_BLANK : seg7(cur_s[15:12]);
            hex2_d = z2_s ? SEG_BLANK : seg7(cur_s[11:8]);
            hex1_d = z1_s ? SEG_BLANK : seg7(cur_s[7:4]);
            hex0_d = seg7(cur_s[3:0]);
        end else begin
            hex3_d = SEG_BLANK;
            hex2_d = SEG_BLANK;
            hex1_d = SEG_BLANK;
            hex0_d = SEG_BLANK;
        end
    end

    // State registers; the key path resets to the released level.
    always_ff @(posedge CLOCK_50Mhz or negedge RESET_N) begin
        if (!RESET_N) begin
            pre_q      <= '0;
            sync_q     <= 2'b11;
            deb_q      <= 1'b1;
            deb_cnt_q  <= '0;
            deb_prev_q <= 1'b1;
            state_q    <= STATE_IDLE;
            grant_q    <= 4'b0000;
            page_q     <= 2'd0;
            dwell_q    <= '0;
            hex0_q     <= SEG_BLANK;
            hex1_q     <= SEG_BLANK;
            hex2_q     <= SEG_BLANK;
            hex3_q     <= SEG_BLANK;
        end else begin
            pre_q      <= pre_d;
            sync_q     <= {sync_q[0], key_n};
            deb_q      <= deb_d;
            deb_cnt_q  <= deb_cnt_d;
            deb_prev_q <= deb_q;
            state_q    <= state_d;
            grant_q    <= grant_d;
            page_q     <= page_d;
            dwell_q    <= dwell_d;
            hex0_q     <= hex0_d;
            hex1_q     <= hex1_d;
            hex2_q     <= hex2_d;
            hex3_q     <= hex3_d;
        end
    end

    assign grant = grant_q;
    assign page  = page_q;
    assign HEX0  = hex0_q;
    assign HEX1  = hex1_q;
    assign HEX2  = hex2_q;
    assign HEX3  = hex3_q;

endmodule

// File: tb/tb_hex_display_scheduler.sv
// Self-checking bench for hex_display_scheduler with short timing parameters
// (TICK_DIV=4, DWELL=2, DEB_CYCLES=3).

module tb_hex_display_scheduler;

    logic        clk;
    logic        rst_n;
    logic        key_n;
    logic        auto_en;
    logic [3:0]  req;
    logic [63:0] src_bcd;
    logic [3:0]  grant;
    logic [1:0]  page;
    logic [6:0]  hex0, hex1, hex2, hex3;

    int n_checks;
    int n_fail;

    localparam logic [6:0] B  = 7'b1111111;
    localparam logic [6:0] S0 = 7'b0000001;
    localparam logic [6:0] S1 = 7'b1001111;
    localparam logic [6:0] S2 = 7'b0010010;
    localparam logic [6:0] S3 = 7'b0000110;
    localparam logic [6:0] S4 = 7'b1001100;
    localparam logic [6:0] S5 = 7'b0100100;
    localparam logic [6:0] S6 = 7'b0100000;
    localparam logic [6:0] S7 = 7'b0001111;
    localparam logic [6:0] S8 = 7'b0000000;
    localparam logic [6:0] S9 = 7'b0000100;

    typedef struct {
        logic [15:0] src;
        logic [27:0] exp_hex;
    } vec_t;

    vec_t vecs[11];

    hex_display_scheduler #(
        .TICK_DIV   (4),
        .DWELL      (2),
        .DEB_CYCLES (3)
    ) dut (
        .CLOCK_50Mhz (clk),
        .RESET_N     (rst_n),
        .key_n       (key_n),
        .auto_en     (auto_en),
        .req         (req),
        .src_bcd     (src_bcd),
        .grant       (grant),
        .page        (page),
        .HEX0        (hex0),
        .HEX1        (hex1),
        .HEX2        (hex2),
        .HEX3        (hex3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    function automatic logic [31:0] hex_all();
        return {4'b0000, hex3, hex2, hex1, hex0};
    endfunction

    // Debounced key press: held low long enough, then released long enough.
    task automatic press_key();
        key_n = 1'b0;
        repeat (6) step();
        key_n = 1'b1;
        repeat (8) step();
    endtask

    // Wait until grant equals want; returns the number of edges taken.
    task automatic wait_grant(input logic [3:0] want, input int limit, output int cycles);
        cycles = 0;
        while ((grant !== want) && (cycles < limit)) begin
            step();
            cycles++;
        end
    endtask

    initial begin
        int cyc;
        n_checks = 0;
        n_fail   = 0;

        vecs[0]  = '{16'h0000, {B,  B,  B,  S0}};
        vecs[1]  = '{16'h0A05, {B,  B,  S0, S5}};
        vecs[2]  = '{16'h0042, {B,  B,  S4, S2}};
        vecs[3]  = '{16'h1234, {S1, S2, S3, S4}};
        vecs[4]  = '{16'h5678, {S5, S6, S7, S8}};
        vecs[5]  = '{16'h9090, {S9, S0, S9, S0}};
        vecs[6]  = '{16'h0100, {B,  S1, S0, S0}};
        vecs[7]  = '{16'hF000, {B,  S0, S0, S0}};
        vecs[8]  = '{16'h00B7, {B,  B,  B,  S7}};
        vecs[9]  = '{16'h000C, {B,  B,  B,  B }};
        vecs[10] = '{16'h0009, {B,  B,  B,  S9}};

        rst_n   = 1'b0;
        key_n   = 1'b1;
        auto_en = 1'b0;
        req     = 4'b0000;
        src_bcd = 64'd0;
        step();
        step();
        chk("reset_grant", {28'd0, grant}, 32'd0);
        chk("reset_page", {30'd0, page}, 32'd0);
        chk("reset_hex", hex_all(), {4'b0000, B, B, B, B});
        rst_n = 1'b1;
        step();

        // Manual mode: first grant searches from page 0 + 1.
        req = 4'b1111;
        step();
        chk("manual_first_grant", {28'd0, grant}, 32'h2);
        chk("manual_first_page", {30'd0, page}, 32'd1);

        // Glitch shorter than the debounce window.
        key_n = 1'b0;
        step();
        step();
        key_n = 1'b1;
        repeat (8) step();
        chk("short_glitch_no_adv", {28'd0, grant}, 32'h2);

        press_key();
        chk("press1_grant", {28'd0, grant}, 32'h4);
        chk("press1_page", {30'd0, page}, 32'd2);
        press_key();
        chk("press2_grant", {28'd0, grant}, 32'h8);
        chk("press2_page", {30'd0, page}, 32'd3);

        // Sole requester: a press keeps the same grant.
        req = 4'b0001;
        step();
        chk("drop_to_src0", {28'd0, grant}, 32'h1);
        press_key();
        chk("sole_requester_press", {28'd0, grant}, 32'h1);

        // Request drops.
        req = 4'b0100;
        step();
        chk("drop_to_page2", {28'd0, grant}, 32'h4);
        req = 4'b1011;
        step();
        chk("drop_1011", {28'd0, grant}, 32'h8);
        req = 4'b0001;
        step();
        chk("drop_0001", {28'd0, grant}, 32'h1);
        req = 4'b0000;
        step();
        chk("drop_all_grant", {28'd0, grant}, 32'h0);
        chk("drop_all_hex_lag", hex_all(), {4'b0000, B, B, B, S0});
        step();
        chk("drop_all_hex_blank", hex_all(), {4'b0000, B, B, B, B});
        chk("idle_page_kept", {30'd0, page}, 32'd0);

        // Idle wake from page 3 searches starting at page 0.
        req = 4'b1000;
        step();
        chk("grant_page3", {28'd0, grant}, 32'h8);
        req = 4'b0000;
        step();
        chk("idle_again", {28'd0, grant}, 32'h0);
        chk("idle_page3", {30'd0, page}, 32'd3);
        req = 4'b0110;
        step();
        chk("idle_wake_grant", {28'd0, grant}, 32'h2);
        step();
        chk("idle_wake_hex", hex_all(), {4'b0000, B, B, B, S0});

        // Asynchronous reset in the middle of a cycle.
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_rst_grant", {28'd0, grant}, 32'h0);
        chk("async_rst_hex", hex_all(), {4'b0000, B, B, B, B});
        req = 4'b0000;
        #2;
        rst_n = 1'b1;
        step();
        chk("post_rst_idle", {28'd0, grant}, 32'h0);

        // Auto rotation between sources 0 and 2.
        auto_en = 1'b1;
        src_bcd[15:0]  = 16'h0042;
        src_bcd[47:32] = 16'h1234;
        req = 4'b1000;
        step();
        req = 4'b0101;
        step();
        chk("auto_grant0", {28'd0, grant}, 32'h1);
        step();
        chk("auto_hex_src0", hex_all(), {4'b0000, B, B, S4, S2});
        wait_grant(4'b0100, 20, cyc);
        chk("auto_reach_src2", {28'd0, grant}, 32'h4);
        step();
        chk("auto_hex_src2", hex_all(), {4'b0000, S1, S2, S3, S4});
        wait_grant(4'b0001, 20, cyc);
        chk("auto_back_src0", {28'd0, grant}, 32'h1);
        chk("auto_dwell_len1", cyc + 1, 32'd8);
        wait_grant(4'b0100, 20, cyc);
        chk("auto_dwell_len2", cyc, 32'd8);

        // Decode table on source 0 in manual mode.
        auto_en = 1'b0;
        req = 4'b0001;
        step();
        chk("decode_grant", {28'd0, grant}, 32'h1);
        for (int i = 0; i < 11; i++) begin
            src_bcd[15:0] = vecs[i].src;
            step();
            chk($sformatf("decode_%h", vecs[i].src), hex_all(), {4'b0000, vecs[i].exp_hex});
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
